// File: rtl/adder_pkg.sv
`default_nettype none
// ==========================================================================
// adder_pkg : shared FSM state encoding and sizing helper for the
//             chunked serial adder.                          rev 1.0
// ==========================================================================
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ==========================================================================
// chunk_adder : CHUNK-bit combinational ripple adder from full-adder cells,
//               also exposing the carry into its MSB.        rev 1.0
// ==========================================================================
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum_out,
  output logic             c_out,
  output logic             c_msb_out
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum_out[i] = a_in[i] ^ b_in[i] ^ w_c[i];
    assign w_c[i+1]   = (a_in[i] & b_in[i]) | (w_c[i] & (a_in[i] ^ b_in[i]));
  end

  assign c_out     = w_c[CHUNK];
  assign c_msb_out = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ==========================================================================
// chunked_serial_adder : WIDTH-bit a+b+cin, CHUNK bits per clock, with
//   valid/ready handshakes. CHUNKED_ADDER_OVERFLOW_EN adds ovf_out. rev 1.0
// ==========================================================================
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy_out
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("chunked_serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               cy_q, cy_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_chunk_cout;
  logic               w_chunk_cmsb;
  logic [WIDTH-1:0]   w_a_next;
  logic [WIDTH-1:0]   w_b_next;
  logic               w_last;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_in      (a_sh_q[CHUNK-1:0]),
    .b_in      (b_sh_q[CHUNK-1:0]),
    .c_in      (cy_q),
    .sum_out   (w_chunk_sum),
    .c_out     (w_chunk_cout),
    .c_msb_out (w_chunk_cmsb)
  );

  // The A register doubles as the sum accumulator: each chunk result fills
  // the MSB end vacated by the shift, so after NCHUNK steps it holds the sum.
  if (CHUNK == WIDTH) begin : g_single
    assign w_a_next = w_chunk_sum;
    assign w_b_next = '0;
  end else begin : g_multi
    assign w_a_next = {w_chunk_sum, a_sh_q[WIDTH-1:CHUNK]};
    assign w_b_next = {{CHUNK{1'b0}}, b_sh_q[WIDTH-1:CHUNK]};
  end

  assign w_last = (cnt_q == CNT_W'(NCHUNK - 1));

`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`else
  logic unused_cmsb;
  assign unused_cmsb = w_chunk_cmsb;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_in) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cy_d    = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = w_a_next;
        b_sh_d = w_b_next;
        cy_d   = w_chunk_cout;
        cnt_d  = cnt_q + 1'b1;
        if (w_last) begin
          sum_d   = w_a_next;
          cout_d  = w_chunk_cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
          ovf_d   = w_chunk_cmsb ^ w_chunk_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready_out  = (state_q == IDLE);
  assign busy_out      = (state_q == RUN);
  assign out_valid_out = (state_q == DONE);
  assign sum_out       = sum_q;
  assign carry_out     = cout_q;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  assign ovf_out       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ==========================================================================
// tb_chunked_serial_adder : four 8-bit instances (CHUNK = 1,2,4,8) checked
//   against a plain-arithmetic reference model.               rev 1.0
// ==========================================================================
module tb_chunked_serial_adder;

  logic            clk;
  logic            rst;
  logic [7:0]      a_in;
  logic [7:0]      b_in;
  logic            c_in;
  logic [3:0]      vld;
  logic [3:0]      rdy;
  logic [3:0]      irdy;
  logic [3:0]      ov;
  logic [3:0]      busy;
  logic [3:0]      cout;
  logic [3:0]      ovf;
  logic [3:0][7:0] sum;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    chunked_serial_adder #(.WIDTH(8), .CHUNK(1 << i)) u_dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .in_valid_in   (vld[i]),
      .in_ready_out  (irdy[i]),
      .a_in          (a_in),
      .b_in          (b_in),
      .c_in          (c_in),
      .out_valid_out (ov[i]),
      .out_ready_in  (rdy[i]),
      .sum_out       (sum[i]),
      .carry_out     (cout[i]),
      .busy_out      (busy[i])
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ,
      .ovf_out       (ovf[i])
`endif
    );
`ifndef CHUNKED_ADDER_OVERFLOW_EN
    assign ovf[i] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance k; with hold=1 the result is left in DONE.
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit hold);
    logic [8:0] model;
    logic [7:0] exp_s;
    logic       exp_c;
    logic       exp_v;
    int         lat;
    int         nbusy;
    int         nch;
    model = 9'(a) + 9'(b) + 9'(c);
    exp_s = model[7:0];
    exp_c = model[8];
    exp_v = (a[7] == b[7]) && (exp_s[7] != a[7]);
    nch   = 8 >> k;
    check($sformatf("ready_before[%0d]", k), 32'(irdy[k]), 32'd1);
    a_in   = a;
    b_in   = b;
    c_in   = c;
    vld[k] = 1'b1;
    rdy[k] = !hold;
    tick();
    vld[k] = 1'b0;
    a_in   = 8'($urandom);
    b_in   = 8'($urandom);
    c_in   = 1'($urandom);
    lat    = 1;
    nbusy  = 0;
    while (!ov[k] && lat < 64) begin
      if (busy[k]) nbusy++;
      tick();
      if (!ov[k]) lat++;
    end
    check($sformatf("latency[%0d]", k), 32'(lat), 32'(nch));
    check($sformatf("busy_cycles[%0d]", k), 32'(nbusy), 32'(nch));
    check($sformatf("sum[%0d] %0h+%0h+%0h", k, a, b, c), 32'(sum[k]), 32'(exp_s));
    check($sformatf("carry[%0d] %0h+%0h+%0h", k, a, b, c), 32'(cout[k]), 32'(exp_c));
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    check($sformatf("ovf[%0d] %0h+%0h+%0h", k, a, b, c), 32'(ovf[k]), 32'(exp_v));
`endif
    if (!hold) begin
      tick();
      check($sformatf("handoff[%0d]", k), 32'({ov[k], irdy[k], busy[k]}), 32'b010);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held_s;
    logic       held_c;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    vld   = '0;
    rdy   = '0;
    a_in  = '0;
    b_in  = '0;
    c_in  = 1'b0;
    tick();
    tick();
    check("reset_ready", 32'(irdy), 32'hF);
    check("reset_valid", 32'(ov), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sum1", 32'(sum[1]), 32'h0);
    check("reset_carry", 32'(cout), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    tick();

    // Directed cases on CHUNK=2.
    run_op(1, 8'h0F, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Backpressure: result must hold while inputs churn.
    run_op(1, 8'h9A, 8'hB7, 1'b1, 1'b1);
    held_s = sum[1];
    held_c = cout[1];
    for (int i = 0; i < 3; i++) begin
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      c_in   = 1'($urandom);
      vld[1] = 1'b1;
      tick();
      check("bp_sum", 32'(sum[1]), 32'(held_s));
      check("bp_carry", 32'(cout[1]), 32'(held_c));
      check("bp_state", 32'({ov[1], irdy[1], busy[1]}), 32'b100);
    end
    rdy[1] = 1'b1;
    tick();
    check("bp_release_no_accept", 32'({ov[1], irdy[1], busy[1]}), 32'b010);
    vld[1] = 1'b0;
    tick();
    check("bp_idle_stays", 32'({ov[1], irdy[1], busy[1]}), 32'b010);

    // Reset in the middle of RUN after two chunks.
    a_in   = 8'h55;
    b_in   = 8'h66;
    c_in   = 1'b0;
    vld[1] = 1'b1;
    tick();
    vld[1] = 1'b0;
    tick();
    tick();
    check("midrun_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_state", 32'({ov[1], irdy[1], busy[1]}), 32'b010);
    check("midrun_rst_sum", 32'(sum[1]), 32'h0);
    check("midrun_rst_carry", 32'(cout[1]), 32'h0);
    tick();
    check("midrun_rst_idle", 32'({ov[1], irdy[1], busy[1]}), 32'b010);
    run_op(1, 8'h3C, 8'h44, 1'b1, 1'b0);

    // Full-width chunk: single-cycle latency.
    run_op(3, 8'h80, 8'h80, 1'b0, 1'b0);

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'h80, 8'h80, 1'b0, 1'b0);
    run_op(1, 8'h10, 8'hF0, 1'b0, 1'b0);
`endif

    // Random sweep over every chunk size.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Multi-cycle WIDTH-bit adder computing a_in + b_in + c_in, CHUNK bits per clock, least significant chunk first. It trades latency for area in wide datapaths where a full-width single-cycle ripple adder is too large or too slow. It sits behind a valid/ready input handshake and presents its result through a valid/ready output handshake.

Parameters:
WIDTH, 16, operand and sum width in bits; WIDTH >= 1.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration error otherwise).
NCHUNK, WIDTH/CHUNK, derived local constant; number of RUN cycles per operation.

Ports:
clk_in  input  1  clock; all state updates on its rising edge.
rst_in  input  1  reset, synchronous, active-high.
in_valid_in  input  1  operands valid.
in_ready_out  output  1  block can accept operands.
a_in  input  WIDTH  operand A.
b_in  input  WIDTH  operand B.
c_in  input  1  carry-in.
out_valid_out  output  1  result valid.
out_ready_in  input  1  consumer accepts the result.
sum_out  output  WIDTH  sum.
carry_out  output  1  carry out of bit WIDTH-1.
busy_out  output  1  high in the RUN state.

Behaviour:
- Reset (rst_in=1 at an edge): state=IDLE, in_ready_out=1, out_valid_out=0, sum_out=0, carry_out=0, busy_out=0, chunk counter=0. Reset has priority over every other event, including mid-RUN and mid-DONE. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE. in_ready_out=1 only in IDLE. busy_out=1 only in RUN. out_valid_out=1 only in DONE.
- IDLE: accept when in_valid_in & in_ready_out at an edge.
  - On accept: latch a_in and b_in into shift registers, latch c_in into the carry register, set counter=0, go to RUN.
  - Operand changes after the accept edge have no effect.
- RUN, each cycle:
  - chunk = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry_reg, a (CHUNK+1)-bit result.
  - The low CHUNK bits shift into sum_reg from the MSB end; sum_reg shifts right by CHUNK.
  - a_sh and b_sh shift right by CHUNK.
  - carry_reg takes chunk[CHUNK].
  - counter increments.
  - When counter==NCHUNK-1 at an edge, go to DONE.
- Latency: out_valid_out rises exactly NCHUNK edges after the accept edge. For CHUNK==WIDTH this is one edge.
- DONE: sum_out and carry_out are driven from registers and held stable while out_valid_out=1 and out_ready_in=0.
  - On out_valid_out & out_ready_in at an edge, go to IDLE.
  - A new operation can be accepted at the following edge at the earliest; there is no accept in the same cycle as result handoff.
- sum_out and carry_out keep their last values in IDLE and RUN. They are valid only when out_valid_out=1.
- in_valid_in asserted outside IDLE is ignored and not queued.
- Arithmetic is unsigned modulo 2^WIDTH with carry_out, bit-identical to a full-width add.

Optional Feature:
Macro CHUNKED_ADDER_OVERFLOW_EN.
- Defined: adds output port ovf_out (1 bit), the signed two's-complement overflow flag, equal to carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Registered with sum_out; reset value 0; valid under out_valid_out.
  - Requires retaining the carry into the MSB from the final chunk.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg: the state enum (IDLE, RUN, DONE) and a clog2 function used to size the counter (max(1, clog2(NCHUNK)) bits).
- One combinational sub-module, chunk_adder (parameter CHUNK): CHUNK-bit ripple add built from full-adder cells. Outputs are the CHUNK-bit sum, carry-out, and carry into its MSB (for the overflow feature).

Test Plan:
- WIDTH=8, CHUNK=2: a=0x0F, b=0x01, c=0 → sum=0x10, carry=0; out_valid_out rises 4 edges after accept; busy_out high for exactly 4 cycles.
- a=0xFF, b=0x01, c=0 → sum=0x00, carry=1. a=0xFF, b=0xFF, c=1 → sum=0xFF, carry=1.
- Backpressure: hold out_ready_in=0 for 3 cycles in DONE while toggling a_in, b_in and in_valid_in. Required: sum_out and carry_out stable, in_ready_out=0, no second operation starts. Release → IDLE next edge.
- Reset mid-RUN after 2 chunks: next edge state=IDLE, all outputs at reset values, in_ready_out=1. Then a=0x3C, b=0x44, c=1 → sum=0x81, carry=0.
- CHUNK=WIDTH=8: a=0x80, b=0x80 → 1-cycle latency, sum=0x00, carry=1. Also run a random sweep of 1000 operands at CHUNK=1, 2, 4, 8 against a reference model.
- With CHUNKED_ADDER_OVERFLOW_EN: a=0x7F, b=0x01 → ovf=1; a=0x80, b=0x80 → ovf=1; a=0x10, b=0xF0 → ovf=0, carry=1.
